// File: rtl/id_hazard_latch.sv
// -----------------------------------------------------------------------------
// id_hazard_latch
//
// IF/ID pipeline latch for the 5-stage MIPS pipeline. It has an integrated
// load-use interlock, a branch flush and forwarding-select generation.
//
// A load-use hazard against the instruction held in ID freezes the PC and
// this latch. It also injects bubbles into EX for LOAD_LAT cycles. A small
// RUN/STALL machine with a 3-bit down-counter times the interlock.
//
// A taken branch flushes the latch to NOP_INST. The flush overrides any
// hazard or stall in progress.
//
// Parameters:
//   XLEN      datapath / instruction / PC width
//   AW        register address width (rs/rt fields below the 6-bit opcode)
//   LOAD_LAT  bubble cycles per load-use hazard, 1..7
//   NOP_INST  instruction word injected on flush or invalid fetch
//
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   if_inst, if_pc4, if_valid     fetched word, PC+4, valid
//   if_ins_type, if_ins_number    debug tags from fetch
//   ex_destR/ex_wreg/ex_m2reg     EX-stage destination, write enable, is-load
//   mem_destR/mem_wreg/mem_m2reg  MEM-stage destination, write enable, is-load
//   branch_taken                  ID resolved a taken branch/jump
//   id_inst, id_pc4, id_valid     latched instruction, PC+4, valid
//   id_ins_type, id_ins_number    latched debug tags
//   pc_hold                       freeze PC and this latch
//   id_bubble                     EX must take a NOP this cycle
//   id_fwda, id_fwdb              forwarding selects for rs / rt
//   bubble_cnt                    saturating count of bubble cycles
// -----------------------------------------------------------------------------
module id_hazard_latch #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     AW       = 5,
    parameter int unsigned     LOAD_LAT = 1,
    parameter logic [XLEN-1:0] NOP_INST = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] if_inst,
    input  logic [XLEN-1:0] if_pc4,
    input  logic            if_valid,
    input  logic [3:0]      if_ins_type,
    input  logic [3:0]      if_ins_number,
    input  logic [AW-1:0]   ex_destR,
    input  logic [AW-1:0]   mem_destR,
    input  logic            ex_wreg,
    input  logic            mem_wreg,
    input  logic            ex_m2reg,
    input  logic            mem_m2reg,
    input  logic            branch_taken,
    output logic [XLEN-1:0] id_inst,
    output logic [XLEN-1:0] id_pc4,
    output logic            id_valid,
    output logic [3:0]      id_ins_type,
    output logic [3:0]      id_ins_number,
    output logic            pc_hold,
    output logic            id_bubble,
    output logic [1:0]      id_fwda,
    output logic [1:0]      id_fwdb,
    output logic [15:0]     bubble_cnt
);

    typedef enum logic {RUN, STALL} state_t;

    state_t          state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] inst_q, inst_d;
    logic [XLEN-1:0] pc4_q, pc4_d;
    logic            valid_q, valid_d;
    logic [3:0]      type_q, type_d;
    logic [3:0]      num_q, num_d;
    logic [15:0]     bcnt_q, bcnt_d;

    logic [AW-1:0]   src_reg [2];
    logic [1:0]      fwd_sel [2];
    logic            hazard;

    // Operand fields sit directly below the 6-bit opcode.
    assign src_reg[0] = inst_q[XLEN-7 -: AW];
    assign src_reg[1] = inst_q[XLEN-7-AW -: AW];

    // Load in EX that targets a source of the instruction held in ID.
    assign hazard = valid_q && ex_m2reg && ex_wreg && (ex_destR != '0) &&
                    ((ex_destR == src_reg[0]) || (ex_destR == src_reg[1]));

    // In STALL the hazard is not re-checked; the counter alone times it out.
    assign pc_hold   = (state_q == STALL) || hazard;
    assign id_bubble = pc_hold;

    // First match wins: EX ALU result, then MEM ALU result, then MEM load data.
    function automatic logic [1:0] fwd_select(input logic [AW-1:0] r);
        logic [1:0] sel;
        sel = 2'b00;
        if (valid_q && (r != '0)) begin
            if (ex_wreg && !ex_m2reg && (ex_destR == r))
                sel = 2'b01;
            else if (mem_wreg && !mem_m2reg && (mem_destR == r))
                sel = 2'b10;
            else if (mem_wreg && mem_m2reg && (mem_destR == r))
                sel = 2'b11;
        end
        return sel;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            assign fwd_sel[gi] = fwd_select(src_reg[gi]);
        end
    endgenerate

    assign id_fwda = fwd_sel[0];
    assign id_fwdb = fwd_sel[1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        inst_d  = inst_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        type_d  = type_q;
        num_d   = num_q;

        if (branch_taken) begin
            // The flush overrides a hazard or stall. PC+4 and the sequence tag
            // still advance so the debug view stays in step with fetch.
            inst_d  = NOP_INST;
            valid_d = 1'b0;
            type_d  = 4'd0;
            pc4_d   = if_pc4;
            num_d   = if_ins_number;
            state_d = RUN;
            cnt_d   = 3'd0;
        end else if (state_q == STALL) begin
            cnt_d = cnt_q - 3'd1;
            if (cnt_q <= 3'd1)
                state_d = RUN;
        end else if (hazard) begin
            // The first bubble is spent here in RUN. The counter covers the rest.
            if (LOAD_LAT > 1) begin
                state_d = STALL;
                cnt_d   = 3'(LOAD_LAT - 1);
            end
        end else begin
            inst_d  = if_valid ? if_inst : NOP_INST;
            type_d  = if_valid ? if_ins_type : 4'd0;
            pc4_d   = if_pc4;
            num_d   = if_ins_number;
            valid_d = if_valid;
        end
    end

    always_comb begin
        bcnt_d = bcnt_q;
        if (id_bubble && (bcnt_q != 16'hFFFF))
            bcnt_d = bcnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            cnt_q   <= 3'd0;
            inst_q  <= NOP_INST;
            pc4_q   <= '1;
            valid_q <= 1'b0;
            type_q  <= 4'd0;
            num_q   <= 4'd0;
            bcnt_q  <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            inst_q  <= inst_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
            type_q  <= type_d;
            num_q   <= num_d;
            bcnt_q  <= bcnt_d;
        end
    end

    assign id_inst       = inst_q;
    assign id_pc4        = pc4_q;
    assign id_valid      = valid_q;
    assign id_ins_type   = type_q;
    assign id_ins_number = num_q;
    assign bubble_cnt    = bcnt_q;

endmodule

// File: tb/tb_id_hazard_latch.sv
// -----------------------------------------------------------------------------
// tb_id_hazard_latch
//
// Directed bench for id_hazard_latch. Two instances with LOAD_LAT=1 and
// LOAD_LAT=3 share every input. Each instance has its own outputs.
// -----------------------------------------------------------------------------
module tb_id_hazard_latch;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_inst, if_pc4;
    logic        if_valid;
    logic [3:0]  if_ins_type, if_ins_number;
    logic [4:0]  ex_destR, mem_destR;
    logic        ex_wreg, mem_wreg, ex_m2reg, mem_m2reg;
    logic        branch_taken;

    // LOAD_LAT=1 instance outputs
    logic [31:0] a_inst, a_pc4;
    logic        a_valid, a_hold, a_bubble;
    logic [3:0]  a_type, a_num;
    logic [1:0]  a_fwda, a_fwdb;
    logic [15:0] a_bcnt;

    // LOAD_LAT=3 instance outputs
    logic [31:0] c_inst, c_pc4;
    logic        c_valid, c_hold, c_bubble;
    logic [3:0]  c_type, c_num;
    logic [1:0]  c_fwda, c_fwdb;
    logic [15:0] c_bcnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    id_hazard_latch #(.XLEN(32), .AW(5), .LOAD_LAT(1), .NOP_INST(32'h0)) u_lat1 (
        .clk(clk), .rst(rst),
        .if_inst(if_inst), .if_pc4(if_pc4), .if_valid(if_valid),
        .if_ins_type(if_ins_type), .if_ins_number(if_ins_number),
        .ex_destR(ex_destR), .mem_destR(mem_destR),
        .ex_wreg(ex_wreg), .mem_wreg(mem_wreg),
        .ex_m2reg(ex_m2reg), .mem_m2reg(mem_m2reg),
        .branch_taken(branch_taken),
        .id_inst(a_inst), .id_pc4(a_pc4), .id_valid(a_valid),
        .id_ins_type(a_type), .id_ins_number(a_num),
        .pc_hold(a_hold), .id_bubble(a_bubble),
        .id_fwda(a_fwda), .id_fwdb(a_fwdb), .bubble_cnt(a_bcnt)
    );

    id_hazard_latch #(.XLEN(32), .AW(5), .LOAD_LAT(3), .NOP_INST(32'h0)) u_lat3 (
        .clk(clk), .rst(rst),
        .if_inst(if_inst), .if_pc4(if_pc4), .if_valid(if_valid),
        .if_ins_type(if_ins_type), .if_ins_number(if_ins_number),
        .ex_destR(ex_destR), .mem_destR(mem_destR),
        .ex_wreg(ex_wreg), .mem_wreg(mem_wreg),
        .ex_m2reg(ex_m2reg), .mem_m2reg(mem_m2reg),
        .branch_taken(branch_taken),
        .id_inst(c_inst), .id_pc4(c_pc4), .id_valid(c_valid),
        .id_ins_type(c_type), .id_ins_number(c_num),
        .pc_hold(c_hold), .id_bubble(c_bubble),
        .id_fwda(c_fwda), .id_fwdb(c_fwdb), .bubble_cnt(c_bcnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    // Advance one rising edge. Inputs change 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Combinational outputs settle 1 ns after an input change.
    task automatic settle();
        #1;
    endtask

    task automatic clear_pipe();
        ex_destR  = 5'd0; ex_wreg  = 1'b0; ex_m2reg  = 1'b0;
        mem_destR = 5'd0; mem_wreg = 1'b0; mem_m2reg = 1'b0;
        branch_taken = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear_pipe();
        tick();
        rst = 1'b1;
    endtask

    // Latch one instruction through a hazard-free RUN cycle.
    task automatic load_inst(input logic [31:0] inst);
        if_inst  = inst;
        if_valid = 1'b1;
        tick();
    endtask

    task automatic set_ex_load(input logic [4:0] rd);
        ex_destR = rd; ex_wreg = 1'b1; ex_m2reg = 1'b1;
    endtask

    // add $9,$8,$10 : rs=8, rt=10
    localparam logic [31:0] ADD_RS8  = 32'h010A4820;
    // add $8,$9,$9  : rs=9, rt=9
    localparam logic [31:0] ADD_RS9  = 32'h01294020;
    // add $8,$0,$9  : rs=0, rt=9
    localparam logic [31:0] ADD_RS0  = 32'h00094020;

    initial begin
        rst = 1'b0;
        if_inst = 32'h0; if_pc4 = 32'h0; if_valid = 1'b0;
        if_ins_type = 4'd0; if_ins_number = 4'd0;
        clear_pipe();

        // ---------------- reset values with the clock running ----------------
        repeat (3) tick();
        check("rst_inst",  a_inst,  32'h0);
        check("rst_pc4",   a_pc4,   32'hFFFFFFFF);
        check("rst_valid", {31'd0, a_valid}, 32'd0);
        check("rst_bcnt",  {16'd0, a_bcnt},  32'd0);
        check("rst_hold",  {31'd0, a_hold},  32'd0);
        check("rst_fwd",   {28'd0, a_fwda, a_fwdb}, 32'd0);

        if_inst = 32'h20080005; if_pc4 = 32'h4; if_valid = 1'b1;
        if_ins_type = 4'd3; if_ins_number = 4'd7;
        rst = 1'b1;
        tick();
        check("first_inst",  a_inst, 32'h20080005);
        check("first_pc4",   a_pc4,  32'h4);
        check("first_valid", {31'd0, a_valid}, 32'd1);
        check("first_tags",  {24'd0, a_type, a_num}, {24'd0, 4'd3, 4'd7});

        // ---------------- load-use, LOAD_LAT=1 -------------------------------
        do_reset();
        load_inst(ADD_RS8);
        if_inst = 32'h11111111;
        set_ex_load(5'd8);
        settle();
        check("l1_hold",   {31'd0, a_hold},   32'd1);
        check("l1_bubble", {31'd0, a_bubble}, 32'd1);
        tick();
        ex_wreg = 1'b0; ex_m2reg = 1'b0; ex_destR = 5'd0;
        mem_destR = 5'd8; mem_wreg = 1'b1; mem_m2reg = 1'b1;
        settle();
        check("l1_hold_after", {31'd0, a_hold}, 32'd0);
        check("l1_inst_held",  a_inst, ADD_RS8);
        check("l1_fwda",       {30'd0, a_fwda}, 32'd3);
        check("l1_fwdb",       {30'd0, a_fwdb}, 32'd0);
        check("l1_bcnt",       {16'd0, a_bcnt}, 32'd1);

        // ---------------- load-use, LOAD_LAT=3 -------------------------------
        do_reset();
        load_inst(ADD_RS8);
        if_inst = 32'h11111111;
        set_ex_load(5'd8);
        settle();
        check("l3_hold_c1", {31'd0, c_hold}, 32'd1);
        tick();
        clear_pipe();
        settle();
        check("l3_hold_c2", {31'd0, c_hold}, 32'd1);
        check("l3_inst_c2", c_inst, ADD_RS8);
        tick();
        check("l3_hold_c3", {31'd0, c_bubble}, 32'd1);
        check("l3_inst_c3", c_inst, ADD_RS8);
        tick();
        check("l3_hold_end", {31'd0, c_hold}, 32'd0);
        check("l3_inst_end", c_inst, ADD_RS8);
        check("l3_bcnt",     {16'd0, c_bcnt}, 32'd3);
        check("l1_bcnt_same_hazard", {16'd0, a_bcnt}, 32'd1);
        tick();
        check("l3_inst_next", c_inst, 32'h11111111);

        // ---------------- forwarding priority --------------------------------
        do_reset();
        load_inst(ADD_RS9);
        ex_destR = 5'd9;  ex_wreg = 1'b1;  ex_m2reg = 1'b0;
        mem_destR = 5'd9; mem_wreg = 1'b1; mem_m2reg = 1'b0;
        settle();
        check("fwd_ex_a", {30'd0, a_fwda}, 32'd1);
        check("fwd_ex_b", {30'd0, a_fwdb}, 32'd1);
        ex_wreg = 1'b0;
        settle();
        check("fwd_mem_alu", {30'd0, a_fwda}, 32'd2);
        mem_m2reg = 1'b1;
        settle();
        check("fwd_mem_ld", {30'd0, a_fwdb}, 32'd3);
        load_inst(ADD_RS0);
        ex_destR = 5'd0; ex_wreg = 1'b1; ex_m2reg = 1'b0;
        settle();
        check("fwd_r0_a",  {30'd0, a_fwda}, 32'd0);
        check("fwd_rt9_b", {30'd0, a_fwdb}, 32'd3);

        // ---------------- flush during STALL (LOAD_LAT=3) ---------------------
        do_reset();
        if_ins_number = 4'd2;
        load_inst(ADD_RS8);
        set_ex_load(5'd8);
        tick();
        clear_pipe();
        branch_taken = 1'b1;
        if_inst = 32'h22222222; if_pc4 = 32'h100; if_ins_number = 4'd9;
        tick();
        branch_taken = 1'b0;
        settle();
        check("fl_inst",  c_inst, 32'h0);
        check("fl_valid", {31'd0, c_valid}, 32'd0);
        check("fl_hold",  {31'd0, c_hold},  32'd0);
        check("fl_pc4",   c_pc4, 32'h100);
        check("fl_num",   {28'd0, c_num}, 32'd9);
        tick();
        check("fl_run_load", c_inst, 32'h22222222);

        // invalid fetch injects a NOP with a cleared type tag
        if_valid = 1'b0; if_inst = 32'h33333333; if_ins_type = 4'd5;
        tick();
        check("inv_inst",  c_inst, 32'h0);
        check("inv_valid", {31'd0, c_valid}, 32'd0);
        check("inv_type",  {28'd0, c_type}, 32'd0);

        // ---------------- bubble counter saturation ---------------------------
        do_reset();
        load_inst(ADD_RS8);
        set_ex_load(5'd8);
        repeat (65534) @(posedge clk);
        #1;
        check("sat_fffe", {16'd0, a_bcnt}, 32'h0000FFFE);
        tick();
        check("sat_ffff", {16'd0, a_bcnt}, 32'h0000FFFF);
        repeat (4500) @(posedge clk);
        #1;
        check("sat_hold_l1", {16'd0, a_bcnt}, 32'h0000FFFF);
        check("sat_hold_l3", {16'd0, c_bcnt}, 32'h0000FFFF);

        // ---------------- reset while stalled -------------------------------
        // The LOAD_LAT=3 instance is mid-stall. Reset must drop the stall.
        rst = 1'b0;
        settle();
        check("rst_mid_bcnt", {16'd0, c_bcnt}, 32'd0);
        tick();
        rst = 1'b1;
        if_inst = 32'h44444444; if_valid = 1'b1;
        tick();
        check("rst_mid_load", c_inst, 32'h44444444);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
